uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKW, default 16: width of the bit-period divisor.
REQ-002 SHALL have parameter DEPTH, default 4: receive FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port i_Clock  input  1  single clock for all logic.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port i_Clks_Per_Bit  input  CLKW  clocks per bit; values below 4 are unsupported.
REQ-007 SHALL have port i_Data_Bits  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 SHALL have port i_Parity_En  input  1  parity bit present.
REQ-009 SHALL have port i_Parity_Odd  input  1  1=odd parity, 0=even parity.
REQ-010 SHALL have port i_Two_Stop  input  1  two stop bits expected.
REQ-011 SHALL have port i_Rx_Ready  input  1  consumer accepts the head word.
REQ-012 SHALL have port i_Clr_Overrun  input  1  clears o_Overrun.
REQ-013 SHALL have port o_Rx_Valid  output  1  FIFO non-empty.
REQ-014 SHALL have port o_Rx_Byte  output  8  head data, LSB first received; unused upper bits zero.
REQ-015 SHALL have port o_Parity_Err  output  1  head word parity mismatch.
REQ-016 SHALL have port o_Frame_Err  output  1  head word had a low stop bit.
REQ-017 SHALL have port o_Break  output  1  head word is a break (all bits low, including stop).
REQ-018 SHALL have port o_Overrun  output  1  sticky: a word was dropped because the FIFO was full.
REQ-019 SHALL have port o_Busy  output  1  receiver is not in IDLE.

Function
REQ-020 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-022 SHALL leave IDLE for START when the synchronized line is low, resetting the bit counter to 0.
REQ-023 SHALL latch i_Clks_Per_Bit, i_Data_Bits, i_Parity_En, i_Parity_Odd and i_Two_Stop on leaving IDLE; changes mid-frame SHALL be ignored.
REQ-024 SHALL, for each bit cell, count 0..N-1, where N is the latched divisor, then restart at 0 and advance to the next bit.
REQ-025 SHALL sample at counts H-1, H and H+1, where H=N>>1; the bit value SHALL be the 2-of-3 majority.
REQ-026 SHALL, in START, return to IDLE at count H+1 if the majority is 1 (glitch rejection); otherwise it SHALL continue to DATA at the end of the cell.
REQ-027 SHALL, in DATA, shift the majority value into bit index 0..D-1; after bit D-1 it SHALL go to PARITY if parity is enabled, else to STOP1.
REQ-028 SHALL compute parity error as (XOR of data bits XOR parity bit XOR i_Parity_Odd) != 0; with parity disabled the error SHALL be 0.
REQ-029 SHALL, in STOP1, set frame error if the majority is 0, and SHALL set break if, in addition, all data bits and the parity bit were 0.
REQ-030 SHALL, when single-stop, push the word at STOP1 count H+1 and enter IDLE in the same cycle, without waiting for the end of the cell.
REQ-031 SHALL, when two-stop, enter STOP2 at the end of STOP1, OR the STOP2 majority into the frame error, then push and enter IDLE at STOP2 count H+1.
REQ-032 SHALL use FIFO entries of {break, frame_err, parity_err, byte[7:0]}.
REQ-033 SHALL assert o_Rx_Valid the cycle after a push into an empty FIFO.
REQ-034 SHALL hold head outputs stable while o_Rx_Valid is high and i_Rx_Ready is low.
REQ-035 SHALL pop on o_Rx_Valid && i_Rx_Ready.
REQ-036 SHALL, on a push while full without a pop, drop the new word and set o_Overrun; on a simultaneous push and pop while full it SHALL accept both and leave o_Overrun unchanged.
REQ-037 SHALL clear o_Overrun on i_Clr_Overrun, except that a drop in the same cycle SHALL win and keep it set.
REQ-038 SHALL keep o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break at zero when the FIFO is empty.

Reset
REQ-039 SHALL, on rst_i asserted at any time including mid-frame, force the FSM to IDLE, empty the FIFO, drive all outputs 0, and set the synchronizer flops to 1; the partial frame SHALL be discarded.
REQ-040 SHALL, after release, require the line to be seen low again before a new frame starts.

Structure
REQ-041 SHALL take from shared package uart_pkg: the FSM state enum, the data-bits encoding, and the FIFO entry struct.
REQ-042 SHALL implement the FIFO as sub-module uart_rx_fifo (synchronous, DEPTH/width parameters, push/pop/full/empty).

Verification
REQ-043 SHALL cover: N=16, 8N1, byte 0xA5 -> one word 0xA5, all error flags 0, o_Rx_Valid high 1 cycle after STOP1 count 9.
REQ-044 SHALL cover: 7E1, data 0x41, parity bit 1 -> o_Rx_Byte=0x41, o_Parity_Err=1.
REQ-045 SHALL cover: 8N2, 0x3C, second stop low -> o_Frame_Err=1, o_Break=0.
REQ-046 SHALL cover: line held low for 12 bit times, 8N1 -> o_Rx_Byte=0x00, o_Frame_Err=1, o_Break=1.
REQ-047 SHALL cover: DEPTH=4, i_Rx_Ready=0, bytes 0x01..0x05 -> 0x01..0x04 retained, o_Overrun=1, 0x05 lost.
REQ-048 SHALL cover: 3-cycle low glitch with N=16 -> no word pushed and o_Busy back to 0 by count 9.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types.
//   rx_state_e  - receiver FSM states
//   data_bits_e - i_Data_Bits encoding (00=5 .. 11=8 data bits)
//   rx_entry_t  - one receive FIFO word {break, frame_err, parity_err, data}
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  typedef enum logic [1:0] {
    DBITS_5 = 2'b00,
    DBITS_6 = 2'b01,
    DBITS_7 = 2'b10,
    DBITS_8 = 2'b11
  } data_bits_e;

  typedef struct packed {
    logic       brk;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  // Index of the last data bit for a given width code (5 bits -> 4 ... 8 bits -> 7).
  function automatic logic [2:0] last_bit_idx(data_bits_e db);
    return 3'd4 + {1'b0, db};
  endfunction

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO for received words.
//   i_Clock, rst_i  - clock, async active-high reset (empties the FIFO)
//   push, wdata     - write request; accepted when not full, or when full and popping
//   pop             - read request; ignored when empty
//   rdata           - head word, forced to zero when empty
//   full, empty     - occupancy flags
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             i_Clock,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_Clock or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: configurable UART receiver with majority-vote sampling and a
// receive FIFO carrying per-word error flags.
//   i_Clock, rst_i   - clock, async active-high reset
//   i_Rx_Serial      - asynchronous serial input, idle high
//   i_Clks_Per_Bit   - bit period in clocks (>= 4)
//   i_Data_Bits      - 00=5 .. 11=8 data bits
//   i_Parity_En/Odd  - parity present / odd parity
//   i_Two_Stop       - two stop bits
//   i_Rx_Ready       - consumer takes the head word
//   i_Clr_Overrun    - clears the sticky overrun flag
//   o_Rx_Valid       - FIFO non-empty
//   o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break - head word (zero when empty)
//   o_Overrun        - a word was dropped on a full FIFO
//   o_Busy           - receiver is mid-frame
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKW  = 16,
  parameter int DEPTH = 4
) (
  input  logic            i_Clock,
  input  logic            rst_i,
  input  logic            i_Rx_Serial,
  input  logic [CLKW-1:0] i_Clks_Per_Bit,
  input  logic [1:0]      i_Data_Bits,
  input  logic            i_Parity_En,
  input  logic            i_Parity_Odd,
  input  logic            i_Two_Stop,
  input  logic            i_Rx_Ready,
  input  logic            i_Clr_Overrun,
  output logic            o_Rx_Valid,
  output logic [7:0]      o_Rx_Byte,
  output logic            o_Parity_Err,
  output logic            o_Frame_Err,
  output logic            o_Break,
  output logic            o_Overrun,
  output logic            o_Busy
);

  localparam logic [CLKW-1:0] ONE = CLKW'(1);

  // Synchronizer; reset to the idle level so a reset never looks like a start bit.
  logic rx_meta, rx_sync;

  always_ff @(posedge i_Clock or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  rx_state_e       state, state_n;
  logic [CLKW-1:0] cnt, n_lat, half;
  data_bits_e      db_lat;
  logic            par_en_lat, par_odd_lat, two_lat;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            samp_a, samp_b, par_bit, ferr, brk;

  logic            cell_end, at_lo, at_mid, at_hi, maj;
  logic            perr, stop_ferr, stop_brk, push;
  rx_entry_t       push_word, head;
  logic            fifo_full, fifo_empty, pop, drop;

  assign half     = n_lat >> 1;
  assign cell_end = (cnt == n_lat - ONE);
  assign at_lo    = (cnt == half - ONE);
  assign at_mid   = (cnt == half);
  assign at_hi    = (cnt == half + ONE);
  // Third vote is the live line value at count H+1.
  assign maj      = maj3(samp_a, samp_b, rx_sync);

  assign perr      = par_en_lat & (^shreg ^ par_bit ^ par_odd_lat);
  // Final stop decision: STOP2 folds its vote into the STOP1 result.
  assign stop_ferr = (state == ST_STOP2) ? (ferr | ~maj) : ~maj;
  assign stop_brk  = (state == ST_STOP2) ? brk : (~maj & (shreg == 8'd0) & ~par_bit);

  always_comb begin
    push_word = '{brk: stop_brk, frame_err: stop_ferr, parity_err: perr, data: shreg};
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      ST_IDLE:   if (!rx_sync) state_n = ST_START;
      ST_START: begin
        if (at_hi && maj)  state_n = ST_IDLE;  // glitch, not a start bit
        else if (cell_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (cell_end && bit_idx == last_bit_idx(db_lat))
          state_n = par_en_lat ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (cell_end) state_n = ST_STOP1;
      ST_STOP1: begin
        // Single stop finishes mid-cell so back-to-back frames are not missed.
        if (!two_lat && at_hi) begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end else if (two_lat && cell_end) begin
          state_n = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (at_hi) begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Frame datapath
  always_ff @(posedge i_Clock or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      n_lat       <= '0;
      db_lat      <= DBITS_8;
      par_en_lat  <= 1'b0;
      par_odd_lat <= 1'b0;
      two_lat     <= 1'b0;
      bit_idx     <= '0;
      shreg       <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      par_bit     <= 1'b0;
      ferr        <= 1'b0;
      brk         <= 1'b0;
    end else if (state == ST_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (!rx_sync) begin
        // Configuration is frozen for the whole frame.
        n_lat       <= i_Clks_Per_Bit;
        db_lat      <= data_bits_e'(i_Data_Bits);
        par_en_lat  <= i_Parity_En;
        par_odd_lat <= i_Parity_Odd;
        two_lat     <= i_Two_Stop;
        shreg       <= '0;
        par_bit     <= 1'b0;
        ferr        <= 1'b0;
        brk         <= 1'b0;
      end
    end else begin
      cnt <= cell_end ? '0 : cnt + ONE;
      if (at_lo)  samp_a <= rx_sync;
      if (at_mid) samp_b <= rx_sync;
      if (at_hi) begin
        case (state)
          ST_DATA:   shreg[bit_idx] <= maj;
          ST_PARITY: par_bit <= maj;
          ST_STOP1: begin
            ferr <= ~maj;
            brk  <= ~maj & (shreg == 8'd0) & ~par_bit;
          end
          default: ;
        endcase
      end
      if (state == ST_DATA && cell_end) bit_idx <= bit_idx + 3'd1;
    end
  end

  assign pop  = !fifo_empty && i_Rx_Ready;
  assign drop = push && fifo_full && !pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .rst_i   (rst_i),
    .push    (push),
    .wdata   (push_word),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky overrun; a drop in the same cycle beats the clear.
  always_ff @(posedge i_Clock or posedge rst_i) begin
    if (rst_i)              o_Overrun <= 1'b0;
    else if (drop)          o_Overrun <= 1'b1;
    else if (i_Clr_Overrun) o_Overrun <= 1'b0;
  end

  assign o_Rx_Valid   = !fifo_empty;
  assign o_Rx_Byte    = head.data;
  assign o_Parity_Err = head.parity_err;
  assign o_Frame_Err  = head.frame_err;
  assign o_Break      = head.brk;
  assign o_Busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;

  logic        clk = 1'b0;
  logic        rst, rx, pen, podd, two, rdy, clr;
  logic [15:0] cpb;
  logic [1:0]  dbits;
  logic        o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun, o_Busy;
  logic [7:0]  o_Rx_Byte;

  int errs = 0;
  int checks = 0;
  int ncyc, first_valid;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLKW(16), .DEPTH(4)) dut (
    .i_Clock        (clk),
    .rst_i          (rst),
    .i_Rx_Serial    (rx),
    .i_Clks_Per_Bit (cpb),
    .i_Data_Bits    (dbits),
    .i_Parity_En    (pen),
    .i_Parity_Odd   (podd),
    .i_Two_Stop     (two),
    .i_Rx_Ready     (rdy),
    .i_Clr_Overrun  (clr),
    .o_Rx_Valid     (o_Rx_Valid),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Parity_Err   (o_Parity_Err),
    .o_Frame_Err    (o_Frame_Err),
    .o_Break        (o_Break),
    .o_Overrun      (o_Overrun),
    .o_Busy         (o_Busy)
  );

  // Reference: the word a frame should produce, from the serial bits sent.
  function automatic logic [10:0] model_word(int db, bit a_pen, bit a_odd, bit a_two,
                                             logic [7:0] d, bit pbit, bit s1, bit s2);
    int         nb = 5 + db;
    logic [7:0] dm = d & 8'((1 << nb) - 1);
    bit pe = a_pen && ((($countones(dm) + int'(pbit) + int'(a_odd)) % 2) != 0);
    bit fe = !s1 || (a_two && !s2);
    bit bk = !s1 && (dm == 8'd0) && !(a_pen && pbit);
    return {bk, fe, pe, dm};
  endfunction

  function automatic bit good_parity(int db, logic [7:0] d, bit a_odd);
    logic [7:0] dm = d & 8'((1 << (5 + db)) - 1);
    return bit'(($countones(dm) + int'(a_odd)) % 2);
  endfunction

  task automatic wait_mon(input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc++;
      if (o_Rx_Valid && first_valid < 0) first_valid = ncyc;
    end
  endtask

  // Drives one frame followed by two idle bit times; optionally scrambles the
  // configuration inputs once the frame is under way.
  task automatic send_frame(input int n, input int db, input bit a_pen, input bit a_odd,
                            input bit a_two, input logic [7:0] d, input bit pbit,
                            input bit s1, input bit s2, input bit scramble);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 5 + db; i++) q.push_back(d[i]);
    if (a_pen) q.push_back(pbit);
    q.push_back(s1);
    if (a_two) q.push_back(s2);
    @(negedge clk);
    cpb = 16'(n); dbits = 2'(db); pen = a_pen; podd = a_odd; two = a_two;
    ncyc = 0; first_valid = -1;
    foreach (q[i]) begin
      rx = q[i];
      if (scramble && i == 1) begin
        cpb   = 16'($urandom_range(4, 40));
        dbits = 2'($urandom);
        pen   = 1'($urandom);
        podd  = 1'($urandom);
        two   = 1'($urandom);
      end
      wait_mon(n);
    end
    rx = 1'b1;
    wait_mon(2 * n);
  endtask

  task automatic pop_word(output logic [10:0] w, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (o_Rx_Valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    w = {o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte};
    if (got) begin
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx = 1'b1; rdy = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rdy = 1'b0; clr = 1'b0;
    cpb = 16'd16; dbits = 2'b11; pen = 1'b0; podd = 1'b0; two = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_Rx_Valid, o_Busy, o_Overrun} !== 3'b000) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 000", {o_Rx_Valid, o_Busy, o_Overrun});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte} !== 11'h000) begin
      errs++; $display("FAIL reset_head: got %h expected 000",
                       {o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte});
    end
    checks++;
    if ({o_Rx_Valid, o_Busy} !== 2'b00) begin
      errs++; $display("FAIL reset_release: got %b expected 00", {o_Rx_Valid, o_Busy});
    end
  endtask

  task automatic test_8n1_basic();
    logic [10:0] w;
    bit got;
    send_frame(16, 3, 0, 0, 0, 8'hA5, 0, 1, 1, 0);
    // Two sync flops, one IDLE cycle, 9 cells of 16, STOP1 count 9, then FIFO update.
    checks++;
    if (first_valid != 9 * 16 + 13) begin
      errs++; $display("FAIL a5_latency: got %0d expected %0d", first_valid, 9 * 16 + 13);
    end
    pop_word(w, got);
    checks++;
    if (!got || w !== model_word(3, 0, 0, 0, 8'hA5, 0, 1, 1)) begin
      errs++; $display("FAIL a5_word: got %h (valid %0d) expected %h", w, got,
                       model_word(3, 0, 0, 0, 8'hA5, 0, 1, 1));
    end
    checks++;
    if ({o_Rx_Valid, o_Rx_Byte, o_Frame_Err} !== 10'h000) begin
      errs++; $display("FAIL empty_zero: got %h expected 000", {o_Rx_Valid, o_Rx_Byte, o_Frame_Err});
    end
  endtask

  task automatic test_7e1_parity();
    logic [10:0] w;
    bit got;
    send_frame(16, 2, 1, 0, 0, 8'h41, 1, 1, 1, 0);
    pop_word(w, got);
    checks++;
    if (!got || w[7:0] !== 8'h41 || w[8] !== 1'b1) begin
      errs++; $display("FAIL parity_7e1: got %h expected byte 41 with parity error", w);
    end
    checks++;
    if (w !== model_word(2, 1, 0, 0, 8'h41, 1, 1, 1)) begin
      errs++; $display("FAIL parity_7e1_model: got %h expected %h", w,
                       model_word(2, 1, 0, 0, 8'h41, 1, 1, 1));
    end
  endtask

  task automatic test_8n2_frame();
    logic [10:0] w;
    bit got;
    send_frame(16, 3, 0, 0, 1, 8'h3C, 0, 1, 0, 0);
    pop_word(w, got);
    checks++;
    if (!got || w !== 11'h23C) begin
      errs++; $display("FAIL stop2_frame: got %h expected 23c", w);
    end
  endtask

  task automatic test_break();
    @(negedge clk);
    cpb = 16'd16; dbits = 2'b11; pen = 1'b0; two = 1'b0;
    ncyc = 0; first_valid = -1;
    rx = 1'b0;
    wait_mon(12 * 16);
    rx = 1'b1;
    wait_mon(12 * 16);
    checks++;
    if (first_valid < 0 || {o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte} !== 11'h600) begin
      errs++; $display("FAIL break_word: got %h (first valid %0d) expected 600",
                       {o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte}, first_valid);
    end
    do_reset();
    checks++;
    if (o_Rx_Valid !== 1'b0) begin
      errs++; $display("FAIL break_reset_flush: got valid %b expected 0", o_Rx_Valid);
    end
  endtask

  task automatic test_overrun();
    logic [10:0] w;
    bit got;
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8, 3, 0, 0, 0, 8'(i), 0, 1, 1, 0);
    checks++;
    if (o_Overrun !== 1'b1) begin
      errs++; $display("FAIL overrun_set: got %b expected 1", o_Overrun);
    end
    checks++;
    if (o_Rx_Byte !== 8'h01) begin
      errs++; $display("FAIL overrun_head_hold: got %h expected 01", o_Rx_Byte);
    end
    for (int i = 1; i <= 4; i++) begin
      pop_word(w, got);
      checks++;
      if (!got || w !== {3'b000, 8'(i)}) begin
        errs++; $display("FAIL overrun_pop%0d: got %h expected %h", i, w, {3'b000, 8'(i)});
      end
    end
    checks++;
    if ({o_Rx_Valid, o_Overrun} !== 2'b01) begin
      errs++; $display("FAIL overrun_drained: got %b expected 01", {o_Rx_Valid, o_Overrun});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (o_Overrun !== 1'b0) begin
      errs++; $display("FAIL overrun_clear: got %b expected 0", o_Overrun);
    end
  endtask

  task automatic test_glitch();
    bit busy5, busy13, saw_valid;
    @(negedge clk);
    cpb = 16'd16; dbits = 2'b11; pen = 1'b0; two = 1'b0;
    busy5 = 1'b0; busy13 = 1'b1; saw_valid = 1'b0;
    rx = 1'b0;
    for (int e = 1; e <= 20 * 16; e++) begin
      @(negedge clk);
      if (e == 3) rx = 1'b1;
      if (e == 5)  busy5 = o_Busy;
      if (e == 13) busy13 = o_Busy;
      if (o_Rx_Valid) saw_valid = 1'b1;
    end
    checks++;
    if (busy5 !== 1'b1 || busy13 !== 1'b0) begin
      errs++; $display("FAIL glitch_busy: got %b%b expected 10", busy5, busy13);
    end
    checks++;
    if (saw_valid) begin
      errs++; $display("FAIL glitch_push: got valid 1 expected 0");
    end
  endtask

  task automatic test_midframe_reset();
    logic [10:0] w;
    bit got;
    @(negedge clk);
    cpb = 16'd16; dbits = 2'b11; pen = 1'b0; two = 1'b0;
    rx = 1'b0;
    repeat (3 * 16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * 16) @(negedge clk);
    checks++;
    if ({o_Busy, o_Rx_Valid} !== 2'b00) begin
      errs++; $display("FAIL midreset_discard: got %b expected 00", {o_Busy, o_Rx_Valid});
    end
    send_frame(16, 3, 0, 0, 0, 8'h5A, 0, 1, 1, 0);
    pop_word(w, got);
    checks++;
    if (!got || w !== 11'h05A) begin
      errs++; $display("FAIL midreset_next: got %h expected 05a", w);
    end
  endtask

  task automatic test_random();
    logic [10:0] w, exp;
    bit got;
    for (int k = 0; k < 40; k++) begin
      int         n  = $urandom_range(4, 24);
      int         db = $urandom_range(0, 3);
      bit         pe = 1'($urandom);
      bit         po = 1'($urandom);
      bit         tw = 1'($urandom);
      logic [7:0] d  = 8'($urandom);
      bit         pb = 1'b0;
      bit         s1 = ($urandom_range(0, 7) != 0);
      bit         s2 = ($urandom_range(0, 7) != 0);
      if (k % 10 == 0) d = 8'h00;
      if (pe) pb = good_parity(db, d, po) ^ ($urandom_range(0, 3) == 0);
      exp = model_word(db, pe, po, tw, d, pb, s1, s2);
      send_frame(n, db, pe, po, tw, d, pb, s1, s2, 1);
      pop_word(w, got);
      checks++;
      if (!got || w !== exp) begin
        errs++; $display("FAIL random%0d n=%0d db=%0d p=%0d%0d two=%0d: got %h expected %h",
                         k, n, db, pe, po, tw, w, exp);
      end
      checks++;
      if (o_Rx_Valid !== 1'b0) begin
        errs++; $display("FAIL random%0d_extra: got valid %b expected 0", k, o_Rx_Valid);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_8n1_basic();
    test_7e1_parity();
    test_8n2_frame();
    test_glitch();
    test_overrun();
    test_break();
    test_midframe_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
